// File: rtl/axi_svt_mem_slave_pkg.sv
// Shared encodings for the AXI3 memory slave: response codes, burst types and
// the write/read channel state machines.
package axi_svt_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Only FIXED and INCR touch storage; WRAP and the reserved code answer SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_svt_mem_slave_ram.sv
// Word-addressed storage with one byte-strobed write port and one registered
// read port; a same-cycle read of the word being written returns the old data.
module axi_svt_mem_slave_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  localparam int IDX_W     = $clog2(MEM_WORDS),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // NOTE: the array has no reset so it maps onto RAM macros; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: non-blocking update means a read in the same cycle as a write sees pre-write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_svt_mem_slave.sv
// AXI3 memory slave: independent single-outstanding write and read channels in
// front of a byte-strobed RAM. FIXED/INCR bursts access storage; others error.
module axi_svt_mem_slave
  import axi_svt_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             awaddr,
  input  logic [3:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic [ID_WIDTH-1:0]     bid,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [31:0]             araddr,
  input  logic [3:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic [ID_WIDTH-1:0]     arid,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic [ID_WIDTH-1:0]     rid,
  output logic                    rlast
);

  localparam int OFFS  = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return addr[OFFS +: IDX_W];
  endfunction

  // INCR wraps naturally at MEM_WORDS through the index width.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] burst);
    return (burst == BURST_INCR) ? idx + IDX_W'(1) : idx;
  endfunction

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_len;
  logic [3:0]       w_cnt;
  logic [1:0]       w_burst;
  logic             w_over;

  r_state_t         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_len;
  logic [3:0]       r_cnt;
  logic [1:0]       r_burst;

  logic                  ram_we;
  logic                  ram_re;
  logic [IDX_W-1:0]      ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ram_we    = (w_state == W_DATA) && wvalid && wready && burst_ok(w_burst);
  assign ram_re    = (arvalid && arready && burst_ok(arburst)) ||
                     (rvalid && rready && !rlast && burst_ok(r_burst));
  assign ram_raddr = (r_state == R_IDLE) ? word_index(araddr) : next_index(r_idx, r_burst);
  assign rdata     = (rresp == RESP_OKAY) ? ram_rdata : '0;

  axi_svt_mem_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk   (aclk),
    .rst   (areset),
    .we    (ram_we),
    .waddr (w_idx),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write channel. w_over flags a beat accepted at awlen without wlast, so a
  // late wlast still errors even though the beat counter has saturated.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_FIXED;
      w_over  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            bid     <= awid;
            w_idx   <= word_index(awaddr);
            w_len   <= awlen;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_over  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_idx <= next_index(w_idx, w_burst);
            if (w_cnt == w_len) w_over <= 1'b1;
            else                w_cnt  <= w_cnt + 4'd1;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (!burst_ok(w_burst) || w_over || (w_cnt != w_len))
                         ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel. The RAM fetch for a beat is issued on the handshake that
  // precedes it, so rdata only changes when a beat is consumed.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rid     <= arid;
            rresp   <= burst_ok(arburst) ? RESP_OKAY : RESP_SLVERR;
            r_idx   <= word_index(araddr);
            r_len   <= arlen;
            r_burst <= arburst;
            r_cnt   <= '0;
            rlast   <= (arlen == 4'd0);
            arready <= 1'b0;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= next_index(r_idx, r_burst);
              r_cnt <= r_cnt + 4'd1;
              rlast <= (r_cnt + 4'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
